// File: rtl/debounce_scan_arbiter.sv
// debounce_scan_arbiter: N-channel push-button debouncer sharing one sample
// prescaler, with press/release events arbitrated round-robin onto a single
// valid/ready event port. Each channel has a one-deep pending slot, and an
// overwrite of an unconsumed event is flagged on overrun.
module debounce_scan_arbiter #(
  parameter int N            = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 20,
  parameter int IDW          = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   noisy,
  output logic [N-1:0]   debounced,
  output logic           evt_valid,
  input  logic           evt_ready,
  output logic [IDW-1:0] evt_id,
  output logic           evt_edge,
  output logic           overrun
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  // A counter at this value that sees one more mismatching tick accepts the level.
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  logic [N-1:0]   r_sync1;
  logic [N-1:0]   r_sync2;
  logic [PW-1:0]  r_presc;
  logic [CW-1:0]  r_cnt [N];
  logic [N-1:0]   r_debounced;
  logic [N-1:0]   r_pend;
  logic [N-1:0]   r_pend_edge;
  logic           r_evt_valid;
  logic [IDW-1:0] r_evt_id;
  logic           r_evt_edge;
  logic [IDW-1:0] r_rr;
  logic           r_overrun;

  logic           w_tick;
  logic [N-1:0]   w_new_evt;
  logic           w_found;
  logic [IDW-1:0] w_sel;
  logic           w_load;
  logic [N-1:0]   w_grant_oh;

  // Two-flop synchronizer per channel for the asynchronous button levels.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= noisy;
      r_sync2 <= r_sync1;
    end
  end

  // Shared prescaler: wraps at TICK_DIV-1 and produces the sample tick.
  always_ff @(posedge clk) begin
    if (!reset_n)    r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  assign w_tick = (r_presc == TICK_LAST);

  // Per-channel stability counters and accepted levels.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_debounced <= '0;
      // NOTE: the counter array is reset element by element; a mid-run reset
      // must not leave partial stability counts behind.
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (r_sync2[i] == r_debounced[i]) begin
          r_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_debounced[i] <= ~r_debounced[i];
            r_cnt[i]       <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  // Flags channels whose level is accepted this cycle; the new level is r_sync2.
  always_comb begin
    w_new_evt = '0;
    for (int i = 0; i < N; i++) begin
      w_new_evt[i] = (r_sync2[i] != r_debounced[i]) && w_tick && (r_cnt[i] == CNT_LAST);
    end
  end

  // Round-robin search of the pending slots starting just after the last grant.
  always_comb begin
    logic [IDW-1:0] idx;
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    w_found = 1'b0;
    w_sel   = '0;
    idx     = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IDW'((int'(r_rr) + off) % N);
      if (!w_found && r_pend[idx]) begin
        w_found = 1'b1;
        w_sel   = idx;
      end
    end
  end

  assign w_load     = !r_evt_valid || evt_ready;
  assign w_grant_oh = (w_load && w_found) ? (N'(1) << w_sel) : '0;

  // One-deep pending slots; a new event wins over a same-cycle grant clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pend      <= '0;
      r_pend_edge <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_pend      <= (r_pend & ~w_grant_oh) | w_new_evt;
      r_pend_edge <= (r_pend_edge & ~w_new_evt) | (r_sync2 & w_new_evt);
      r_overrun   <= |(w_new_evt & r_pend & ~w_grant_oh);
    end
  end

  // Event output register: loads when empty or when the consumer takes it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_evt_edge  <= 1'b0;
      r_rr        <= IDW'(N - 1);
    end else if (w_load) begin
      r_evt_valid <= w_found;
      if (w_found) begin
        r_evt_id   <= w_sel;
        r_evt_edge <= r_pend_edge[w_sel];
        r_rr       <= w_sel;
      end
    end
  end

  assign debounced = r_debounced;
  assign evt_valid = r_evt_valid;
  assign evt_id    = r_evt_id;
  assign evt_edge  = r_evt_edge;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_debounce_scan_arbiter.sv
// Self-checking bench for debounce_scan_arbiter: table-driven press/release
// vectors, hand-written corner sequences and a randomized run, all checked
// cycle by cycle against a behavioural model.
module tb_debounce_scan_arbiter;

  localparam int N            = 4;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int IDW          = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   noisy;
  logic [N-1:0]   debounced;
  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  logic           evt_edge;
  logic           overrun;

  debounce_scan_arbiter #(
    .N(N), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS), .IDW(IDW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .noisy(noisy), .debounced(debounced),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
    .evt_edge(evt_edge), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sync is noisy delayed two cycles, a tick occurs every
  // TICK_DIV-th cycle after reset, and a channel flips after STABLE_TICKS
  // consecutive ticks that see a differing level.
  bit [N-1:0] m_d1, m_d2, m_deb, m_pend, m_pedge;
  int         m_run [N];
  int         m_phase, m_rr;
  bit         m_valid, m_edge, m_ovr;
  logic [1:0] m_id;

  task automatic model_step();
    bit         tick;
    bit [N-1:0] nev;
    int         g;
    if (!reset_n) begin
      m_d1 = '0; m_d2 = '0; m_deb = '0; m_pend = '0; m_pedge = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_phase = 0; m_rr = N - 1; m_valid = 0; m_edge = 0; m_ovr = 0; m_id = '0;
      return;
    end
    tick = (m_phase == TICK_DIV - 1);
    nev  = '0;
    for (int i = 0; i < N; i++) begin
      if (m_d2[i] == m_deb[i]) m_run[i] = 0;
      else if (tick) begin
        m_run[i]++;
        if (m_run[i] == STABLE_TICKS) begin
          m_deb[i] = ~m_deb[i];
          m_run[i] = 0;
          nev[i]   = 1'b1;
        end
      end
    end
    g = -1;
    if (!m_valid || evt_ready) begin
      for (int off = 1; off <= N && g < 0; off++)
        if (m_pend[(m_rr + off) % N]) g = (m_rr + off) % N;
      if (g >= 0) begin
        m_valid = 1; m_id = 2'(g); m_edge = m_pedge[g]; m_rr = g;
      end else begin
        m_valid = 0;
      end
    end
    m_ovr = 0;
    for (int i = 0; i < N; i++) begin
      if (nev[i]) begin
        if (m_pend[i] && i != g) m_ovr = 1;
        m_pend[i]  = 1'b1;
        m_pedge[i] = m_deb[i];
      end else if (i == g) begin
        m_pend[i] = 1'b0;
      end
    end
    m_phase = tick ? 0 : m_phase + 1;
    m_d2 = m_d1;
    m_d1 = noisy;
  endtask

  function automatic logic [31:0] dut_obs();
    return {23'b0, debounced, evt_valid, evt_valid ? evt_id : 2'b00,
            evt_valid ? evt_edge : 1'b0, overrun};
  endfunction

  function automatic logic [31:0] model_obs();
    return {23'b0, m_deb, m_valid, m_valid ? m_id : 2'b00,
            m_valid ? m_edge : 1'b0, m_ovr};
  endfunction

  // One clock: model consumes the current inputs, DUT clocks, compare at negedge.
  task automatic step();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check("model", dut_obs(), model_obs());
  endtask

  typedef struct {
    logic [3:0] noisy;
    logic [3:0] exp_deb;
    logic [1:0] exp_id;
    logic       exp_edge;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, k, ovr_cnt, first_k;
    logic [2:0] got [$];

    vecs[0] = '{4'b0001, 4'b0001, 2'd0, 1'b1};
    vecs[1] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[2] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
    vecs[3] = '{4'b1100, 4'b1100, 2'd3, 1'b1};
    vecs[4] = '{4'b1000, 4'b1000, 2'd2, 1'b0};
    vecs[5] = '{4'b0000, 4'b0000, 2'd3, 1'b0};

    reset_n = 1'b0; noisy = '0; evt_ready = 1'b1;
    step(); step();
    check("reset_outputs", {23'b0, debounced, evt_valid, evt_id, evt_edge, overrun}, 32'd0);
    reset_n = 1'b1;
    step();

    // Clean press/release per table entry: latency, single-cycle event.
    for (int v = 0; v < 6; v++) begin
      noisy = vecs[v].noisy;
      k = 0;
      while (debounced !== vecs[v].exp_deb && k < 30) begin
        step();
        k++;
      end
      check($sformatf("latency_%0d", v), 32'(k >= 11 && k <= 14), 32'd1);
      step();
      check($sformatf("event_%0d", v), {evt_valid, evt_id, evt_edge},
            {1'b1, vecs[v].exp_id, vecs[v].exp_edge});
      step();
      check($sformatf("one_shot_%0d", v), evt_valid, 1'b0);
      repeat (4) step();
    end

    // Bounce rejection on channel 1.
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      if (c % 5 == 0) noisy[1] = ~noisy[1];
      step();
      if (debounced !== 4'b0000 || evt_valid !== 1'b0) bad++;
    end
    noisy[1] = 1'b0;
    repeat (4) step();
    check("bounce_quiet", bad, 0);
    for (int i = 0; i < N; i++) check($sformatf("bounce_cnt%0d", i), 32'(dut.r_cnt[i]), 32'd0);

    // Simultaneous press with backpressure.
    evt_ready = 1'b0;
    noisy = 4'b1110;
    k = 0;
    while (!evt_valid && k < 30) begin
      step();
      k++;
    end
    check("stall_first", {evt_valid, evt_id, evt_edge}, {1'b1, 2'd1, 1'b1});
    bad = 0;
    repeat (20) begin
      step();
      if ({evt_valid, evt_id, evt_edge} !== {1'b1, 2'd1, 1'b1}) bad++;
    end
    check("stall_hold", bad, 0);
    evt_ready = 1'b1;
    step();
    check("stall_id2", {evt_valid, evt_id, evt_edge}, {1'b1, 2'd2, 1'b1});
    step();
    check("stall_id3", {evt_valid, evt_id, evt_edge}, {1'b1, 2'd3, 1'b1});
    step();
    check("stall_idle", evt_valid, 1'b0);
    noisy = 4'b0000;
    repeat (40) step();

    // Overrun: press, release, press with the consumer stalled.
    evt_ready = 1'b0;
    ovr_cnt = 0;
    bad = 0;
    noisy[0] = 1'b1;
    repeat (20) begin step(); ovr_cnt += int'(overrun); end
    check("ovr_held", {evt_valid, evt_id, evt_edge}, {1'b1, 2'd0, 1'b1});
    noisy[0] = 1'b0;
    repeat (20) begin
      step();
      ovr_cnt += int'(overrun);
      if ({evt_valid, evt_id, evt_edge} !== {1'b1, 2'd0, 1'b1}) bad++;
    end
    check("ovr_pend_set", 32'(dut.r_pend[0]), 32'd1);
    noisy[0] = 1'b1;
    repeat (20) begin
      step();
      ovr_cnt += int'(overrun);
      if ({evt_valid, evt_id, evt_edge} !== {1'b1, 2'd0, 1'b1}) bad++;
    end
    check("ovr_hold", bad, 0);
    check("ovr_pulses", ovr_cnt, 1);
    evt_ready = 1'b1;
    step();
    check("ovr_second", {evt_valid, evt_id, evt_edge}, {1'b1, 2'd0, 1'b1});
    step();
    check("ovr_idle", evt_valid, 1'b0);

    // Fairness: ch0 re-pressed while ch2 pending; grants go 0, 2, 0.
    evt_ready = 1'b0;
    noisy = 4'b0000;
    repeat (20) step();
    noisy = 4'b0101;
    repeat (20) step();
    check("fair_g0", {evt_valid, evt_id, evt_edge}, {1'b1, 2'd0, 1'b0});
    evt_ready = 1'b1;
    step();
    check("fair_g1", {evt_valid, evt_id, evt_edge}, {1'b1, 2'd2, 1'b1});
    step();
    check("fair_g2", {evt_valid, evt_id, evt_edge}, {1'b1, 2'd0, 1'b1});
    step();
    check("fair_idle", evt_valid, 1'b0);

    // Reset mid-operation with an event held and all channels pressed.
    evt_ready = 1'b0;
    noisy = 4'b1111;
    repeat (20) step();
    check("pre_reset", {debounced, evt_valid}, {4'b1111, 1'b1});
    reset_n = 1'b0;
    step();
    check("mid_reset", {23'b0, debounced, evt_valid, evt_id, evt_edge, overrun}, 32'd0);
    reset_n = 1'b1;
    evt_ready = 1'b1;
    first_k = -1;
    for (int c = 0; c < 40; c++) begin
      step();
      if (evt_valid === 1'b1) begin
        got.push_back({evt_id, evt_edge});
        if (first_k < 0) first_k = c + 1;
      end
    end
    check("reset_re_count", got.size(), 4);
    check("reset_re_delay", 32'(first_k >= 11), 32'd1);
    for (int i = 0; i < 4 && i < got.size(); i++)
      check($sformatf("reset_re_%0d", i), got[i], {2'(i), 1'b1});

    // Randomized run against the model.
    for (int seg = 0; seg < 60; seg++) begin
      int prob, mode;
      case ($urandom_range(0, 2))
        0:       prob = 3;
        1:       prob = 10;
        default: prob = 25;
      endcase
      mode = $urandom_range(0, 2);
      for (int c = 0; c < 50; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(0, prob - 1) == 0) noisy[i] = ~noisy[i];
        evt_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        reset_n   = ($urandom_range(0, 999) != 0);
        step();
      end
    end
    reset_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
